alu_divider: RTL

Sequential 32-bit unsigned restoring divider for the ALU datapath. It is the subtract-side counterpart to the combinational adder: one trial subtraction per clock over 32 iterations. It takes a dividend and divisor on a start pulse and returns quotient, remainder and a divide-by-zero flag with a one-cycle done strobe. It sits beside the adder behind the ALU operation mux and is driven by the control FSM.

---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_sub_stage.sv | 21 ++
 rtl/alu_divider.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width, divider FSM states, iteration counter width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

   localparam int WIDTH  = 32;
   localparam int ITER_W = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_t;

endpackage

// File: rtl/alu_sub_stage.sv
// Combinational trial subtract: o_diff = i_a - i_b, o_borrow set when i_a < i_b.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; result tracks inputs continuously.
//
// Ports:
//   i_a, i_b  : W-bit unsigned operands
//   o_diff    : W-bit difference (modulo 2**W)
//   o_borrow  : 1 when i_a < i_b
module alu_sub_stage #(
   parameter int W = 33
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   output logic [W-1:0] o_diff,
   output logic         o_borrow
);

   // Zero-extend by one bit so the top bit of the result is the borrow.
   assign {o_borrow, o_diff} = {1'b0, i_a} - {1'b0, i_b};

endmodule

// File: rtl/alu_divider.sv
// Sequential unsigned restoring divider, one trial subtraction per clock.
// Latency: done strobes 32 cycles after the accepting edge (nonzero divisor), 1 cycle for divide-by-zero.
// Backpressure: start is ignored while busy; results held until the next accepted start.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request, sampled while busy=0 (IDLE or DONE)
//   R2, R3     : dividend, divisor (sampled with start)
//   R1, rem    : quotient, remainder (valid with done, held afterwards)
//   busy       : high while iterating
//   done       : one-cycle result strobe
//   dz         : divide-by-zero flag, valid with done
module alu_divider
   import alu_pkg::*;
#(
   parameter int WIDTH = alu_pkg::WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] R2,
   input  logic [WIDTH-1:0] R3,
   output logic [WIDTH-1:0] R1,
   output logic [WIDTH-1:0] rem,
   output logic             busy,
   output logic             done,
   output logic             dz
);

   div_state_t          r_state;
   div_state_t          w_next_state;

   logic [WIDTH-1:0]    r_quot;
   logic [WIDTH-1:0]    r_prem;
   logic [WIDTH-1:0]    r_div;
   logic [ITER_W-1:0]   r_count;
   logic [WIDTH-1:0]    r_q_out;
   logic [WIDTH-1:0]    r_rem_out;
   logic                r_dz;

   logic                w_accept;
   logic                w_div_zero;
   logic                w_last_iter;
   logic [WIDTH:0]      w_trial_a;
   logic [WIDTH:0]      w_trial_b;
   logic [WIDTH:0]      w_diff;
   logic                w_borrow;
   logic [WIDTH-1:0]    w_new_quot;
   logic [WIDTH-1:0]    w_new_rem;
   logic                w_unused;

   assign w_accept    = start && (r_state != RUN);
   assign w_div_zero  = (R3 == '0);
   assign w_last_iter = (r_count == ITER_W'(WIDTH - 1));

   // The bit shifted out of the partial remainder is kept as the trial MSB.
   // With a divisor >= 2**(WIDTH-1) the shifted remainder needs WIDTH+1 bits,
   // and dropping that bit would give wrong quotients for large divisors.
   assign w_trial_a = {r_prem, r_quot[WIDTH-1]};
   assign w_trial_b = {1'b0, r_div};

   alu_sub_stage #(
      .W (WIDTH + 1)
   ) u_sub (
      .i_a      (w_trial_a),
      .i_b      (w_trial_b),
      .o_diff   (w_diff),
      .o_borrow (w_borrow)
   );

   // On no-borrow the difference is below the divisor, so its MSB is always 0.
   // On borrow the trial value is below the divisor, so its MSB is 0 as well.
   assign w_new_quot = {r_quot[WIDTH-2:0], ~w_borrow};
   assign w_new_rem  = w_borrow ? w_trial_a[WIDTH-1:0] : w_diff[WIDTH-1:0];
   assign w_unused   = w_diff[WIDTH];

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_next_state = w_div_zero ? DONE : RUN;
            end
         end
         RUN: begin
            if (w_last_iter) begin
               w_next_state = DONE;
            end
         end
         DONE: begin
            if (start) begin
               w_next_state = w_div_zero ? DONE : RUN;
            end else begin
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   // Status outputs, decoded from the state register only
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (r_state)
         RUN:     busy = 1'b1;
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_quot    <= '0;
         r_prem    <= '0;
         r_div     <= '0;
         r_count   <= '0;
         r_q_out   <= '0;
         r_rem_out <= '0;
         r_dz      <= 1'b0;
      end else if (w_accept) begin
         if (w_div_zero) begin
            r_q_out   <= '1;
            r_rem_out <= R2;
            r_dz      <= 1'b1;
         end else begin
            r_quot  <= R2;
            r_div   <= R3;
            r_prem  <= '0;
            r_count <= '0;
            r_dz    <= 1'b0;
         end
      end else if (r_state == RUN) begin
         r_quot  <= w_new_quot;
         r_prem  <= w_new_rem;
         r_count <= r_count + ITER_W'(1);
         // Publish only on the final iteration so outputs stay stable mid-run.
         if (w_last_iter) begin
            r_q_out   <= w_new_quot;
            r_rem_out <= w_new_rem;
         end
      end
   end

   assign R1  = r_q_out;
   assign rem = r_rem_out;
   assign dz  = r_dz;

endmodule
